// File: rtl/fir_mac_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fir_mac_sequencer
// Function : Shifts one sample into the FIR delay line per handshake, then
//            walks every tap through a pipelined signed multiply-accumulate.
// Revision : 1.0  initial release
// ============================================================================
module fir_mac_sequencer #(
  parameter  int INPUT_WIDTH  = 16,
  parameter  int COEFF_WIDTH  = 16,
  parameter  int COEFF_SIZE   = 64,
  localparam int ADDRESS_SIZE = $clog2(COEFF_SIZE),
  localparam int OUTPUT_WIDTH = INPUT_WIDTH + COEFF_WIDTH + ADDRESS_SIZE
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [INPUT_WIDTH-1:0]  in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [INPUT_WIDTH-1:0]  shift_data,
  output logic                    shift_enable,
  output logic [ADDRESS_SIZE-1:0] tap_address,
  input  logic [INPUT_WIDTH-1:0]  tap_data,
  output logic [ADDRESS_SIZE-1:0] coeff_address,
  input  logic [COEFF_WIDTH-1:0]  coeff_data,
  output logic [OUTPUT_WIDTH-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int c_prod_width = INPUT_WIDTH + COEFF_WIDTH;

  localparam logic [2:0] c_idle  = 3'd0;
  localparam logic [2:0] c_shift = 3'd1;
  localparam logic [2:0] c_mac   = 3'd2;
  localparam logic [2:0] c_drain = 3'd3;
  localparam logic [2:0] c_done  = 3'd4;

  localparam logic [ADDRESS_SIZE-1:0] c_last_addr = ADDRESS_SIZE'(COEFF_SIZE - 1);
  localparam logic [ADDRESS_SIZE-1:0] c_addr_one  = ADDRESS_SIZE'(1);

  logic [2:0]                      r_state;
  logic [INPUT_WIDTH-1:0]          r_shift_data;
  logic [ADDRESS_SIZE-1:0]         r_tap_address;
  logic signed [c_prod_width-1:0]  r_product;
  logic                            r_product_valid;
  logic signed [OUTPUT_WIDTH-1:0]  r_acc;

  logic [c_prod_width-1:0]         w_tap_ext;
  logic [c_prod_width-1:0]         w_coeff_ext;
  logic [c_prod_width-1:0]         w_product;
  logic signed [OUTPUT_WIDTH-1:0]  w_product_ext;

  // Low half of the product of sign-extended operands is the exact signed product.
  assign w_tap_ext     = {{COEFF_WIDTH{tap_data[INPUT_WIDTH-1]}}, tap_data};
  assign w_coeff_ext   = {{INPUT_WIDTH{coeff_data[COEFF_WIDTH-1]}}, coeff_data};
  assign w_product     = w_tap_ext * w_coeff_ext;
  assign w_product_ext = {{ADDRESS_SIZE{r_product[c_prod_width-1]}}, r_product};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state         <= c_idle;
      r_shift_data    <= '0;
      r_tap_address   <= '0;
      r_product       <= '0;
      r_product_valid <= 1'b0;
      r_acc           <= '0;
    end else begin
      case (r_state)
        c_idle: begin
          if (in_valid) begin
            r_shift_data <= in_data;
            r_state      <= c_shift;
          end
        end
        c_shift: begin
          r_acc           <= '0;
          r_tap_address   <= '0;
          r_product_valid <= 1'b0;
          r_state         <= c_mac;
        end
        c_mac: begin
          // Product is registered, so the accumulator trails the address by one cycle.
          r_product       <= w_product;
          r_product_valid <= 1'b1;
          if (r_product_valid) begin
            r_acc <= r_acc + w_product_ext;
          end
          if (r_tap_address == c_last_addr) begin
            r_tap_address <= '0;
            r_state       <= c_drain;
          end else begin
            r_tap_address <= r_tap_address + c_addr_one;
          end
        end
        c_drain: begin
          r_acc           <= r_acc + w_product_ext;
          r_product_valid <= 1'b0;
          r_state         <= c_done;
        end
        c_done: begin
          if (out_ready) begin
            r_state <= c_idle;
          end
        end
        default: r_state <= c_idle;
      endcase
    end
  end

  assign in_ready      = (r_state == c_idle);
  assign shift_enable  = (r_state == c_shift);
  assign out_valid     = (r_state == c_done);
  assign shift_data    = r_shift_data;
  assign tap_address   = r_tap_address;
  assign coeff_address = r_tap_address;
  assign out_data      = r_acc;

endmodule
`default_nettype wire

// File: tb/tb_fir_mac_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fir_mac_sequencer
// Function : Self-checking bench with delay line, coefficient ROM and FIR model.
// Revision : 1.0  initial release
// ============================================================================
module tb_fir_mac_sequencer;

  localparam int IW  = 16;
  localparam int CS  = 64;
  localparam int AW  = 6;
  localparam int OW  = 38;
  localparam int LAT = CS + 3;   // cycles from accepting edge to first out_valid cycle
  localparam int GAP = CS + 4;   // accepting edges back-to-back

  logic          clock = 1'b0;
  logic          reset;
  logic [IW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] shift_data;
  logic          shift_enable;
  logic [AW-1:0] tap_address;
  logic [IW-1:0] tap_data;
  logic [AW-1:0] coeff_address;
  logic [15:0]   coeff_data;
  logic [OW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;

  fir_mac_sequencer dut (
    .clock(clock), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .shift_data(shift_data), .shift_enable(shift_enable),
    .tap_address(tap_address), .tap_data(tap_data),
    .coeff_address(coeff_address), .coeff_data(coeff_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clock = ~clock;

  // Environment: tapped delay line and coefficient ROM.
  logic [IW-1:0]      dl [CS];
  logic signed [15:0] coef [CS];
  logic               dl_clear;

  always @(posedge clock) begin
    if (dl_clear) begin
      for (int i = 0; i < CS; i++) dl[i] <= '0;
    end else if (shift_enable) begin
      for (int i = CS-1; i > 0; i--) dl[i] <= dl[i-1];
      dl[0] <= shift_data;
    end
  end

  assign tap_data   = dl[tap_address];
  assign coeff_data = coef[coeff_address];

  // Reference model state.
  int     hist [CS];
  longint exp_q [$];
  int     acc_q [$];
  int     tests, fails;
  int     ncyc, n_acc, se_count, last_acc, last_acc_data;
  bit     spacing_chk, have_last, prev_se, prev_ov;
  longint last_result;

  function automatic void check(string name, longint got, longint expv);
    tests++;
    if (got !== expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, expv);
    end
  endfunction

  function automatic longint golden();
    longint acc = 0;
    for (int k = 0; k < CS; k++) acc += longint'(hist[k]) * longint'(coef[k]);
    return acc;
  endfunction

  // Monitor: predicts acceptance at the coming edge and checks results.
  initial begin
    forever begin
      @(negedge clock);
      ncyc++;
      if (reset) begin
        check("coeff_addr", coeff_address, tap_address);
        if (shift_enable) begin
          se_count++;
          check("shift_width", prev_se, 0);
          check("shift_data", $signed(shift_data), last_acc_data);
        end
        if (out_valid && !prev_ov) begin
          if (acc_q.size() == 0) check("spurious_valid", 1, 0);
          else check("latency", ncyc - acc_q[0], LAT);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) check("unexpected_out", 1, 0);
          else begin
            last_result = longint'($signed(out_data));
            check("result", last_result, exp_q.pop_front());
            void'(acc_q.pop_front());
          end
        end
        if (in_valid && in_ready) begin
          for (int k = CS-1; k > 0; k--) hist[k] = hist[k-1];
          hist[0] = int'($signed(in_data));
          exp_q.push_back(golden());
          acc_q.push_back(ncyc);
          if (spacing_chk && have_last) check("spacing", ncyc - last_acc, GAP);
          last_acc      = ncyc;
          have_last     = 1'b1;
          last_acc_data = hist[0];
          n_acc++;
        end
      end
      prev_se = reset && shift_enable;
      prev_ov = reset && out_valid;
    end
  end

  task automatic set_coeffs(input int mode);
    for (int k = 0; k < CS; k++) begin
      case (mode)
        0:       coef[k] = 16'(k + 1);
        1:       coef[k] = 16'sh8000;
        default: coef[k] = 16'($urandom);
      endcase
    end
  endtask

  task automatic send_only(input logic [IW-1:0] s);
    int start = n_acc;
    int n = 0;
    @(posedge clock); #1;
    in_data  = s;
    in_valid = 1'b1;
    while (n_acc == start && n < 300) begin @(posedge clock); #1; n++; end
    in_valid = 1'b0;
    if (n_acc == start) check("accept_timeout", 0, 1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin @(posedge clock); #1; n++; end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
  endtask

  typedef struct {
    int            mode;
    logic [IW-1:0] sample;
    int            reps;
    longint        expect_last;
  } vec_t;

  vec_t   vecs [4];
  int     start, se0, n;
  longint held;

  initial begin
    vecs[0] = '{0, 16'h0001, 1,  64'sd1};
    vecs[1] = '{0, 16'h0000, 63, 64'sd64};
    vecs[2] = '{1, 16'h8000, 64, 64'sd68719476736};
    vecs[3] = '{1, 16'h7FFF, 64, -64'sd68717379584};

    reset = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; dl_clear = 1'b1;
    set_coeffs(0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_in_ready",     in_ready, 1);
    check("rst_shift_enable", shift_enable, 0);
    check("rst_out_valid",    out_valid, 0);
    check("rst_out_data",     out_data, 0);
    check("rst_shift_data",   shift_data, 0);
    check("rst_tap_address",  tap_address, 0);
    @(posedge clock); #1;
    reset = 1'b1; dl_clear = 1'b0;

    // Impulse through ramp coefficients, then full-scale extremes.
    for (int v = 0; v < 4; v++) begin
      set_coeffs(vecs[v].mode);
      for (int r = 0; r < vecs[v].reps; r++) begin
        send_only(vecs[v].sample);
        wait_drain();
      end
      check($sformatf("vec%0d_last", v), last_result, vecs[v].expect_last);
    end

    // Backpressure: result must hold and new samples must be refused.
    set_coeffs(2);
    out_ready = 1'b0;
    send_only(16'h1234);
    n = 0;
    while (!out_valid && n < 300) begin @(posedge clock); #1; n++; end
    check("bp_reach_done", out_valid, 1);
    held  = longint'($signed(out_data));
    start = n_acc;
    se0   = se_count;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin in_valid = 1'b1; in_data = 16'h7777; end
      if (i == 8) in_valid = 1'b0;
      @(negedge clock);
      check("bp_valid",    out_valid, 1);
      check("bp_data",     longint'($signed(out_data)), held);
      check("bp_in_ready", in_ready, 0);
      @(posedge clock); #1;
    end
    check("bp_no_accept", n_acc - start, 0);
    check("bp_no_shift",  se_count - se0, 0);
    out_ready = 1'b1;
    @(negedge clock);
    @(posedge clock);
    @(negedge clock);
    check("bp_release_valid",    out_valid, 0);
    check("bp_release_in_ready", in_ready, 1);
    wait_drain();

    // Busy drop: in_valid held through the whole computation.
    spacing_chk = 1'b1; have_last = 1'b0;
    start = n_acc; se0 = se_count;
    @(posedge clock); #1;
    in_valid = 1'b1; in_data = 16'h0123;
    n = 0;
    while (n_acc < start + 2 && n < 400) begin @(posedge clock); #1; in_data = 16'h0456; n++; end
    in_valid = 1'b0;
    check("busy_accepts", n_acc - start, 2);
    wait_drain();
    check("busy_shift_pulses", se_count - se0, 2);
    spacing_chk = 1'b0;

    // Reset in the middle of the MAC walk.
    send_only(16'($urandom));
    n = 0;
    while (int'(tap_address) != 30 && n < 300) begin @(negedge clock); n++; end
    check("mac_addr30_reached", tap_address, 30);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_in_ready",     in_ready, 1);
    check("mid_rst_out_valid",    out_valid, 0);
    check("mid_rst_shift_enable", shift_enable, 0);
    check("mid_rst_tap_address",  tap_address, 0);
    void'(exp_q.pop_back());
    void'(acc_q.pop_back());
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b1;
    send_only(16'($urandom));
    wait_drain();

    // Back-to-back random stream.
    spacing_chk = 1'b1; have_last = 1'b0;
    start = n_acc;
    @(posedge clock); #1;
    in_valid = 1'b1; in_data = 16'($urandom);
    n = 0;
    while (n_acc < start + 200 && n < 200 * 70) begin
      @(posedge clock); #1;
      in_data = 16'($urandom);
      n++;
    end
    in_valid = 1'b0;
    check("b2b_accepts", n_acc - start, 200);
    wait_drain();
    spacing_chk = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
